// File: rtl/if_fetch.sv
// if_fetch: RV32I fetch stage. Credit-limited imem requests, an in-order
// {pc, inst} response FIFO to decode, and redirect flush with stale drop.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic          run_q, run_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [31:0]   pc_q [DEPTH];
  logic [31:0]   pc_d [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];

  logic        req_fire;
  logic        rsp_ok;
  logic        push;
  logic        pop;
  logic [31:0] new_pc;
  logic        unused_pc_lsb;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign new_pc        = {redirect_pc[31:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign imem_req_valid = run_q && (({1'b0, infl_q} + {1'b0, cnt_q}) < CAP);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // a response with nothing outstanding is a protocol error and is ignored
  assign rsp_ok         = imem_rsp_valid && (infl_q != '0);
  assign push           = rsp_ok && (drop_q == '0);

  assign out_valid = (cnt_q != '0);
  assign out_pc    = out_valid ? pc_q[rd_q] : '0;
  assign out_inst  = out_valid ? inst_q[rd_q] : NOP;
  assign pop       = out_valid && out_ready;

  always_comb begin
    run_d      = 1'b1;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    infl_d     = infl_q + {{(CW-1){1'b0}}, req_fire}
                        - {{(CW-1){1'b0}}, rsp_ok};
    cnt_d      = cnt_q + {{(CW-1){1'b0}}, push}
                       - {{(CW-1){1'b0}}, pop};
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp_ok && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (push) begin
      pc_d[wr_q]   = rsp_pc_q;
      inst_d[wr_q] = imem_rsp_data;
      wr_d         = inc(wr_q);
      rsp_pc_d     = rsp_pc_q + 32'd4;
    end
    if (pop) rd_d = inc(rd_q);
    // everything still outstanding after this edge belongs to the old path
    if (redirect_valid) begin
      fetch_pc_d = new_pc;
      rsp_pc_d   = new_pc;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      drop_d     = infl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      infl_q     <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      pc_q       <= '{default: '0};
      inst_q     <= '{default: NOP};
    end else begin
      run_q      <= run_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      infl_q     <= infl_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

`ifndef SYNTHESIS
  a_rsp_has_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (infl_q != '0)
  ) else $error("if_fetch: imem response with no request in flight");
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized fetch traffic against a queue-based model of
// the expected instruction stream, with a decoupled output monitor.
module tb_if_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int npop = 0;
  int lat_mode = 0;
  int stale_n = 0;
  int last_due = 0;
  bit run_m = 1'b0;
  logic [31:0] exp_next = RST_PC;

  // expected decode stream of the current path
  logic [31:0] exp_pc_q [$];
  logic [31:0] exp_in_q [$];
  // memory model: outstanding request addresses and their due cycles
  logic [31:0] maddr_q [$];
  int          mdue_q [$];

  if_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory response driver
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n && maddr_q.size() > 0 && mdue_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(maddr_q[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // monitor: compares what the DUT presents against the model
  always @(negedge clk) begin
    int live;
    int buf_n;
    if (!rst_n) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, NOP);
    end else begin
      live  = maddr_q.size() - stale_n;
      buf_n = exp_pc_q.size() - live;
      chk("req_valid", 32'(imem_req_valid),
          32'(run_m && (maddr_q.size() + buf_n < DEPTH)));
      chk("out_valid", 32'(out_valid), 32'(buf_n != 0));
      if (out_valid && out_ready) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got pc %h expected none", out_pc);
        end else begin
          chk("out_pc", out_pc, exp_pc_q[0]);
          chk("out_inst", out_inst, exp_in_q[0]);
          void'(exp_pc_q.pop_front());
          void'(exp_in_q.pop_front());
          npop++;
        end
      end else if (!out_valid) begin
        chk("idle_pc", out_pc, 32'd0);
        chk("idle_inst", out_inst, NOP);
      end
    end
  end

  // scoreboard: records edge events and pushes expected outputs
  always @(negedge clk) begin
    int due;
    #1;
    if (!rst_n) begin
      exp_pc_q.delete();
      exp_in_q.delete();
      maddr_q.delete();
      mdue_q.delete();
      stale_n  = 0;
      last_due = 0;
      run_m    = 1'b0;
      exp_next = RST_PC;
    end else begin
      if (imem_rsp_valid && maddr_q.size() > 0) begin
        void'(maddr_q.pop_front());
        void'(mdue_q.pop_front());
        if (stale_n > 0) stale_n--;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_next);
        case (lat_mode)
          0: due = cyc + 1;
          1: due = cyc + 3;
          default: due = cyc + int'($urandom_range(1, 3));
        endcase
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        maddr_q.push_back(imem_req_addr);
        mdue_q.push_back(due);
        if (!redirect_valid) begin
          exp_pc_q.push_back(exp_next);
          exp_in_q.push_back(word_at(exp_next));
        end
        exp_next = exp_next + 32'd4;
      end
      if (redirect_valid) begin
        exp_pc_q.delete();
        exp_in_q.delete();
        stale_n  = maddr_q.size();
        exp_next = redirect_pc & 32'hFFFF_FFFC;
      end
      run_m = 1'b1;
    end
  end

  task automatic drive(input bit rq, input bit ordy, input bit rv,
                       input logic [31:0] rpc);
    imem_req_ready = rq;
    out_ready      = ordy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFF8;
      2: return 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, pick_pc());
  endtask

  initial begin
    bit done;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_mode = 0;
    repeat (20) drive(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'd0);
    lat_mode = 1;
    repeat (6) drive(1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    repeat (12) drive(1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    repeat (8) drive(1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'd0);
    lat_mode = 2;
    rand_phase(1500);
    lat_mode = 0;
    repeat (8) drive(1'b1, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'd0);
    lat_mode = 2;
    rand_phase(400);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      if (exp_pc_q.size() == 0 && maddr_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_pc_q.size());
    end
    checks++;
    if (npop < 200) begin
      failures++;
      $display("FAIL progress: got %0d outputs expected at least 200", npop);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
